// File: rtl/move_ctrl.sv
// Chess move sequencer: turns mouse clicks into pick/place moves and drives the board write port.
// Latency: click event 3 cycles after an LMB rising edge; the FSM acts 1 cycle later; commit is 2 writes then move_done.
// Backpressure: none. Clicks arriving while a move is being written are dropped, not queued.
//
// Ports: clk/rst_n (async active-low), lmb + mouse_xpos/ypos from the mouse, board[row][col] snapshot in;
//        sel_valid/sel_square/turn status, board_we/addr/wdata write port, move_done/capture pulses out.
module move_ctrl #(
    parameter int BOARD_X0 = 256,
    parameter int BOARD_Y0 = 128,
    parameter int SQ_LOG2  = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   lmb,
    input  logic [11:0]            mouse_xpos,
    input  logic [11:0]            mouse_ypos,
    input  logic [0:7][0:7][3:0]   board,
    output logic                   sel_valid,
    output logic [5:0]             sel_square,
    output logic                   turn,
    output logic                   board_we,
    output logic [5:0]             board_addr,
    output logic [3:0]             board_wdata,
    output logic                   move_done,
    output logic                   capture
);

    typedef enum logic [2:0] {IDLE, PICKED, WR_DST, WR_SRC, DONE} state_t;

    // Board is 8 squares of 2**SQ_LOG2 pixels on each side.
    localparam logic [11:0] SPAN = 12'(8 << SQ_LOG2);

    state_t       state;
    logic         sync1, sync2, sync3;
    logic         evt;
    logic [5:0]   evt_sq;
    logic [3:0]   evt_piece;
    logic         cap;

    logic [12:0]  dx, dy;
    logic         on_board;
    logic [5:0]   cur_sq;
    logic         evt_own;

    // 13-bit subtraction: cursors left of / above the origin set bit 12 and are off-board.
    assign dx       = {1'b0, mouse_xpos} - 13'(BOARD_X0);
    assign dy       = {1'b0, mouse_ypos} - 13'(BOARD_Y0);
    assign on_board = !dx[12] && !dy[12] && (dx[11:0] < SPAN) && (dy[11:0] < SPAN);
    assign cur_sq   = {dy[SQ_LOG2 +: 3], dx[SQ_LOG2 +: 3]};
    assign evt_own  = (evt_piece != 4'h0) && (evt_piece[3] == turn);

    // Synchroniser, edge detect and click capture. Off-board clicks never become events.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            sync3     <= 1'b0;
            evt       <= 1'b0;
            evt_sq    <= 6'd0;
            evt_piece <= 4'h0;
        end else begin
            sync1 <= lmb;
            sync2 <= sync1;
            sync3 <= sync2;
            evt   <= sync2 && !sync3 && on_board;
            if (sync2 && !sync3) begin
                evt_sq    <= cur_sq;
                evt_piece <= board[cur_sq[5:3]][cur_sq[2:0]];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            sel_valid   <= 1'b0;
            sel_square  <= 6'd0;
            turn        <= 1'b0;
            board_we    <= 1'b0;
            board_addr  <= 6'd0;
            board_wdata <= 4'h0;
            move_done   <= 1'b0;
            capture     <= 1'b0;
            cap         <= 1'b0;
        end else begin
            board_we  <= 1'b0;
            move_done <= 1'b0;
            capture   <= 1'b0;
            case (state)
                IDLE: begin
                    if (evt && evt_own) begin
                        sel_square <= evt_sq;
                        sel_valid  <= 1'b1;
                        state      <= PICKED;
                    end
                end
                PICKED: begin
                    if (evt) begin
                        if (evt_sq == sel_square) begin
                            sel_valid <= 1'b0;
                            state     <= IDLE;
                        end else if (evt_own) begin
                            sel_square <= evt_sq;
                        end else begin
                            // Destination write is set up here so board_we rises on entry to WR_DST.
                            board_we    <= 1'b1;
                            board_addr  <= evt_sq;
                            board_wdata <= board[sel_square[5:3]][sel_square[2:0]];
                            cap         <= (evt_piece != 4'h0);
                            state       <= WR_DST;
                        end
                    end
                end
                WR_DST: begin
                    board_we    <= 1'b1;
                    board_addr  <= sel_square;
                    board_wdata <= 4'h0;
                    state       <= WR_SRC;
                end
                WR_SRC: begin
                    move_done <= 1'b1;
                    capture   <= cap;
                    turn      <= ~turn;
                    sel_valid <= 1'b0;
                    state     <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_move_ctrl.sv
// Self-checking bench for move_ctrl: directed steps plus randomized clicks against a rules-level model.
// Latency: checks the 4-cycle press-to-select delay and the dst/src/done write timing.
// Backpressure: none; each click is fully settled before the next press.
module tb_move_ctrl;

    typedef logic [0:7][0:7][3:0] board_t;
    typedef struct { int cyc; logic [5:0] a; logic [3:0] d; } wr_t;
    typedef struct { int cyc; logic c; } dn_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        lmb = 1'b0;
    logic [11:0] mouse_xpos = 12'd0;
    logic [11:0] mouse_ypos = 12'd0;
    board_t      brd;
    logic        sel_valid, turn, board_we, move_done, capture;
    logic [5:0]  sel_square, board_addr;
    logic [3:0]  board_wdata;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    wr_t wq[$];
    dn_t dq[$];

    // Reference model state
    board_t     mb;
    bit         msel;
    logic [5:0] msq;
    bit         mturn;
    int         en;
    logic [5:0] ea0, ea1;
    logic [3:0] ed0;
    bit         edone, ecap;

    move_ctrl dut (
        .clk(clk), .rst_n(rst_n), .lmb(lmb),
        .mouse_xpos(mouse_xpos), .mouse_ypos(mouse_ypos), .board(brd),
        .sel_valid(sel_valid), .sel_square(sel_square), .turn(turn),
        .board_we(board_we), .board_addr(board_addr), .board_wdata(board_wdata),
        .move_done(move_done), .capture(capture)
    );

    always #5 clk = ~clk;

    function automatic board_t init_board();
        board_t b;
        logic [2:0] back [8] = '{3'd4, 3'd2, 3'd3, 3'd5, 3'd6, 3'd3, 3'd2, 3'd4};
        b = '0;
        for (int c = 0; c < 8; c++) begin
            b[0][c] = {1'b1, back[c]};
            b[1][c] = 4'h9;
            b[6][c] = 4'h1;
            b[7][c] = {1'b0, back[c]};
        end
        return b;
    endfunction

    // Board owner: applies writes one cycle after board_we, restores the start position on reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) brd <= init_board();
        else if (board_we) brd[board_addr[5:3]][board_addr[2:0]] <= board_wdata;
    end

    // Output monitor, sampled away from the active edge.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && board_we) wq.push_back('{cyc, board_addr, board_wdata});
        if (rst_n && move_done) dq.push_back('{cyc, capture});
    end

    task automatic chk(string tag, logic [255:0] obs, logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sx(int c); return 256 + c * 64 + 20; endfunction
    function automatic int sy(int r); return 128 + r * 64 + 20; endfunction

    task automatic model_reset();
        mb = init_board();
        msel = 0;
        msq = 6'd0;
        mturn = 0;
    endtask

    // Applies one click to the model using the game rules directly.
    task automatic model_click(int x, int y);
        int dx, dy, r, c;
        logic [3:0] p;
        logic [5:0] sq;
        dx = x - 256;
        dy = y - 128;
        en = 0; edone = 0; ecap = 0;
        if (dx < 0 || dx >= 512 || dy < 0 || dy >= 512) return;
        r = dy / 64;
        c = dx / 64;
        sq = {3'(r), 3'(c)};
        p = mb[r][c];
        if (!msel) begin
            if (p != 0 && p[3] == mturn) begin msel = 1; msq = sq; end
        end else if (sq == msq) begin
            msel = 0;
        end else if (p != 0 && p[3] == mturn) begin
            msq = sq;
        end else begin
            en = 2;
            ea0 = sq;
            ed0 = mb[msq[5:3]][msq[2:0]];
            ea1 = msq;
            edone = 1;
            ecap = (p != 0);
            mb[r][c] = ed0;
            mb[msq[5:3]][msq[2:0]] = 4'h0;
            mturn = !mturn;
            msel = 0;
        end
    endtask

    task automatic press(int x, int y);
        @(negedge clk);
        wq.delete();
        dq.delete();
        mouse_xpos = 12'(x);
        mouse_ypos = 12'(y);
        lmb = 1'b1;
    endtask

    task automatic release_and_check(int x, int y);
        lmb = 1'b0;
        repeat (14) @(negedge clk);
        model_click(x, y);
        chk("sel_valid", 256'(sel_valid), 256'(msel));
        chk("sel_square", 256'(sel_square), 256'(msq));
        chk("turn", 256'(turn), 256'(mturn));
        chk("n_writes", 256'(wq.size()), 256'(en));
        chk("n_done", 256'(dq.size()), 256'(edone));
        chk("board", brd, mb);
        if (en == 2 && wq.size() == 2) begin
            chk("wr_dst_addr", 256'(wq[0].a), 256'(ea0));
            chk("wr_dst_data", 256'(wq[0].d), 256'(ed0));
            chk("wr_src_addr", 256'(wq[1].a), 256'(ea1));
            chk("wr_src_data", 256'(wq[1].d), 256'(0));
            chk("wr_back_to_back", 256'(wq[1].cyc - wq[0].cyc), 256'(1));
            if (dq.size() == 1) begin
                chk("done_after_src", 256'(dq[0].cyc - wq[1].cyc), 256'(1));
                chk("capture", 256'(dq[0].c), 256'(ecap));
            end
        end
    endtask

    task automatic click(int x, int y, int hold);
        press(x, y);
        repeat (hold) @(negedge clk);
        release_and_check(x, y);
    endtask

    task automatic check_reset_outputs(string tag);
        chk({tag, "_sel_valid"}, 256'(sel_valid), 256'(0));
        chk({tag, "_sel_square"}, 256'(sel_square), 256'(0));
        chk({tag, "_turn"}, 256'(turn), 256'(0));
        chk({tag, "_board_we"}, 256'(board_we), 256'(0));
        chk({tag, "_board_addr"}, 256'(board_addr), 256'(0));
        chk({tag, "_board_wdata"}, 256'(board_wdata), 256'(0));
        chk({tag, "_move_done"}, 256'(move_done), 256'(0));
        chk({tag, "_capture"}, 256'(capture), 256'(0));
    endtask

    initial begin
        bit got;
        int x, y;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("post_rst");

        // Pick white pawn [6][0]; selection appears 4 cycles after the press.
        press(300, 550);
        repeat (3) @(negedge clk);
        chk("lat_sel_early", 256'(sel_valid), 256'(0));
        @(negedge clk);
        chk("lat_sel_on_time", 256'(sel_valid), 256'(1));
        release_and_check(300, 550);
        chk("pick_sq_60", 256'(sel_square), 256'(6'o60));

        // Quiet move to empty [4][0].
        click(300, 420, 2);
        chk("turn_black", 256'(turn), 256'(1));

        // Black pawn [1][3] captures white pawn [6][4].
        click(sx(3), sy(1), 2);
        click(sx(4), sy(6), 3);

        // Deselect, reselect, off-board.
        click(sx(1), sy(6), 2);
        click(sx(1), sy(6), 2);
        chk("deselect", 256'(sel_valid), 256'(0));
        click(sx(1), sy(6), 2);
        click(sx(1), sy(7), 2);
        chk("reselect_sq", 256'(sel_square), 256'(6'o71));
        click(100, 100, 2);
        click(sx(1), sy(7), 2);
        click(sx(2), sy(6), 2);
        click(sx(2), sy(5), 2);
        // Black to move: white piece ignored, long hold gives a single pick.
        click(sx(3), sy(6), 2);
        click(sx(0), sy(1), 50);
        chk("hold_single", 256'(sel_valid), 256'(1));
        click(sx(0), sy(1), 2);

        // Randomized clicks, mostly on or near the board.
        for (int i = 0; i < 80; i++) begin
            x = $urandom_range(200, 800);
            y = $urandom_range(70, 690);
            if ($urandom_range(0, 9) == 0) x = $urandom_range(0, 4095);
            click(x, y, $urandom_range(2, 8));
        end

        // Reset in the middle of a commit.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        click(sx(5), sy(6), 2);
        press(sx(5), sy(4));
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = board_we;
        end
        chk("commit_started", 256'(got), 256'(1));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_commit");
        lmb = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        chk("board_restored", brd, init_board());
        click(300, 550, 2);
        chk("idle_after_rst", 256'(sel_valid), 256'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
